evm_result_reader: RTL and testbench

EVM_RESULT_READER -- requirements
Module: evm_result_reader

---
 rtl/evm_pkg.sv | 44 ++++
 rtl/evm_hold_timer.sv | 34 +++
 rtl/evm_result_reader.sv | 188 ++++++++++++++++++
 tb/tb_evm_result_reader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/evm_pkg.sv
// Shared types and constants for the EVM result reader.
//   evm_state_e : readout FSM states
//   evm_best_t  : winner index plus tie flag
//   evm_pick()  : picks the largest count; the lowest index wins ties
package evm_pkg;

  localparam int unsigned NUM_CAND = 4;
  localparam int unsigned CAND_W   = 2;
  localparam int unsigned COUNT_W  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StPress,
    StGap,
    StEmit
  } evm_state_e;

  typedef struct packed {
    logic [CAND_W-1:0] idx;
    logic              tie;
  } evm_best_t;

  function automatic evm_best_t evm_pick(input logic [NUM_CAND-1:0][COUNT_W-1:0] counts);
    logic [COUNT_W-1:0] max_v;
    int unsigned        n_max;
    evm_best_t          r;
    max_v = counts[0];
    r.idx = '0;
    // Strict '>' keeps the lowest index on equal counts.
    for (int i = 1; i < NUM_CAND; i++) begin
      if (counts[i] > max_v) begin
        max_v = counts[i];
        r.idx = CAND_W'(i);
      end
    end
    n_max = 0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (counts[i] == max_v) n_max++;
    end
    r.tie = (n_max > 1);
    return r;
  endfunction

endpackage

// File: rtl/evm_hold_timer.sv
// Loadable down-counter timing the PRESS and GAP phases.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : load load_val_i this edge (takes priority over counting)
//   load_val_i    : phase length minus one
//   expire_o      : high on the last cycle of the loaded phase (count is zero)
module evm_hold_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             expire_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/evm_result_reader.sv
// Drives a voting machine through result mode: presses each candidate button in turn, captures
// the displayed count, then emits one valid/ready record per candidate and reports the winner.
//   clock, reset          : clock, async active-low reset
//   start, abort          : begin a readout (IDLE only) / cancel a readout in progress
//   result                : count shown by the machine for the pressed button
//   mode, candidateN_button : registered drive to the machine
//   out_valid/out_ready, out_cand, out_count : per-candidate record stream
//   busy, done, winner, tie : status; winner/tie valid from done until the next start
module evm_result_reader
  import evm_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 12,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [COUNT_W-1:0] result,
  output logic               mode,
  output logic               candidate1_button,
  output logic               candidate2_button,
  output logic               candidate3_button,
  output logic               candidate4_button,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CAND_W-1:0]  out_cand,
  output logic [COUNT_W-1:0] out_count,
  output logic               busy,
  output logic               done,
  output logic [CAND_W-1:0]  winner,
  output logic               tie
);

  localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GapLoad  = 8'(GAP_CYCLES - 1);

  evm_state_e                         state_d, state_q;
  logic [CAND_W-1:0]                  k_d, k_q;
  logic [NUM_CAND-1:0][COUNT_W-1:0]   count_d, count_q;
  logic [NUM_CAND-1:0]                btn_d, btn_q;
  logic                               mode_d, mode_q;
  logic                               out_valid_d, out_valid_q;
  logic [CAND_W-1:0]                  out_cand_d, out_cand_q;
  logic [COUNT_W-1:0]                 out_count_d, out_count_q;
  logic                               done_d, done_q;
  logic [CAND_W-1:0]                  winner_d, winner_q;
  logic                               tie_d, tie_q;
  logic                               timer_load;
  logic [7:0]                         timer_val;
  logic                               timer_expire;
  evm_best_t                          best;

  evm_hold_timer #(
    .Width (8)
  ) u_timer (
    .clk_i      (clock),
    .rst_ni     (reset),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .expire_o   (timer_expire)
  );

  assign best = evm_pick(count_q);

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    count_d    = count_q;
    done_d     = 1'b0;
    winner_d   = winner_q;
    tie_d      = tie_q;
    timer_load = 1'b0;
    timer_val  = '0;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d    = StPress;
          k_d        = '0;
          winner_d   = '0;
          tie_d      = 1'b0;
          timer_load = 1'b1;
          timer_val  = HoldLoad;
        end
      end
      StPress: begin
        if (timer_expire) begin
          count_d[k_q] = result;
          state_d      = StGap;
          timer_load   = 1'b1;
          timer_val    = GapLoad;
        end
      end
      StGap: begin
        if (timer_expire) begin
          if (k_q == CAND_W'(NUM_CAND - 1)) begin
            state_d = StEmit;
            k_d     = '0;
          end else begin
            state_d    = StPress;
            k_d        = k_q + CAND_W'(1);
            timer_load = 1'b1;
            timer_val  = HoldLoad;
          end
        end
      end
      StEmit: begin
        if (out_valid_q && out_ready) begin
          if (k_q == CAND_W'(NUM_CAND - 1)) begin
            state_d  = StIdle;
            k_d      = '0;
            done_d   = 1'b1;
            winner_d = best.idx;
            tie_d    = best.tie;
          end else begin
            k_d = k_q + CAND_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything, including a capture or final handshake on this edge.
    if (abort && state_q != StIdle) begin
      state_d    = StIdle;
      k_d        = '0;
      count_d    = count_q;
      done_d     = 1'b0;
      winner_d   = winner_q;
      tie_d      = tie_q;
      timer_load = 1'b1;
      timer_val  = '0;
    end
  end

  // Machine drive and record outputs are registered from the next state so they line up
  // with the state they belong to.
  always_comb begin
    btn_d       = (state_d == StPress) ? (NUM_CAND'(1) << k_d) : '0;
    mode_d      = (state_d == StPress) || (state_d == StGap);
    out_valid_d = (state_d == StEmit);
    out_cand_d  = (state_d == StEmit) ? k_d : '0;
    out_count_d = (state_d == StEmit) ? count_q[k_d] : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      k_q         <= '0;
      count_q     <= '0;
      btn_q       <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_cand_q  <= '0;
      out_count_q <= '0;
      done_q      <= 1'b0;
      winner_q    <= '0;
      tie_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      count_q     <= count_d;
      btn_q       <= btn_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_cand_q  <= out_cand_d;
      out_count_q <= out_count_d;
      done_q      <= done_d;
      winner_q    <= winner_d;
      tie_q       <= tie_d;
    end
  end

  assign candidate1_button = btn_q[0];
  assign candidate2_button = btn_q[1];
  assign candidate3_button = btn_q[2];
  assign candidate4_button = btn_q[3];
  assign mode              = mode_q;
  assign out_valid         = out_valid_q;
  assign out_cand          = out_cand_q;
  assign out_count         = out_count_q;
  assign busy              = (state_q != StIdle);
  assign done              = done_q;
  assign winner            = winner_q;
  assign tie               = tie_q;

endmodule

// File: tb/tb_evm_result_reader.sv
// Directed bench for evm_result_reader with a stub voting machine that returns a fixed count
// per pressed button. Inputs change and outputs are sampled on the falling clock edge.
module tb_evm_result_reader;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [3:0] result;
  logic       mode;
  logic       b1, b2, b3, b4;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_cand;
  logic [3:0] out_count;
  logic       busy, done, tie;
  logic [1:0] winner;

  logic [3:0] stub [4];
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clock = ~clock;

  evm_result_reader dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .abort             (abort),
    .result            (result),
    .mode              (mode),
    .candidate1_button (b1),
    .candidate2_button (b2),
    .candidate3_button (b3),
    .candidate4_button (b4),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_cand          (out_cand),
    .out_count         (out_count),
    .busy              (busy),
    .done              (done),
    .winner            (winner),
    .tie               (tie)
  );

  // Stub machine: shows the stored count of whichever button is held while in result mode.
  always_comb begin
    result = 4'd0;
    if (mode) begin
      if (b1)      result = stub[0];
      else if (b2) result = stub[1];
      else if (b3) result = stub[2];
      else if (b4) result = stub[3];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_stub(input logic [3:0] c0, input logic [3:0] c1,
                          input logic [3:0] c2, input logic [3:0] c3);
    stub[0] = c0; stub[1] = c1; stub[2] = c2; stub[3] = c3;
  endtask

  // Full readout: start pulse, optional stall of record 1, optional start re-pulse while busy.
  // Cycle c is sampled on the falling edge after the c-th rising edge following the start edge.
  task automatic run_readout(input string tag, input int stall_len, input bit repulse,
                             input logic [1:0] exp_win, input logic exp_tie);
    int         first_valid, nrec, ndone, done_cyc, bad_btn, bad_stall, stalled;
    logic [1:0] rc [4];
    logic [3:0] rn [4];
    logic [3:0] btn, exp_btn;
    logic [3:0] one;
    one = 4'b0001;
    first_valid = -1; nrec = 0; ndone = 0; done_cyc = -1;
    bad_btn = 0; bad_stall = 0; stalled = 0;
    for (int i = 0; i < 4; i++) begin rc[i] = '0; rn[i] = '0; end
    @(negedge clock);
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clock);
    for (int c = 0; c < 80 + stall_len; c++) begin
      @(negedge clock);
      start = (repulse && c == 20) ? 1'b1 : 1'b0;
      btn = {b4, b3, b2, b1};
      if ($countones(btn) > 1) bad_btn++;
      if (c < 56) begin
        exp_btn = ((c % 14) < 12) ? (one << (c / 14)) : 4'b0000;
        if (btn !== exp_btn || mode !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) bad_btn++;
      end else if (btn !== 4'b0000 || mode !== 1'b0) begin
        bad_btn++;
      end
      if (out_valid && first_valid < 0) first_valid = c;
      if (done) begin ndone++; done_cyc = c; end
      out_ready = 1'b1;
      if (out_valid && nrec == 1 && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
        if (out_cand !== 2'd1 || out_count !== stub[1]) bad_stall++;
      end
      if (out_valid && out_ready) begin
        if (nrec < 4) begin rc[nrec] = out_cand; rn[nrec] = out_count; end
        nrec++;
      end
    end
    check_val({tag, "_first_valid"}, first_valid, 56);
    check_val({tag, "_btn_pattern"}, bad_btn, 0);
    check_val({tag, "_nrec"}, nrec, 4);
    for (int i = 0; i < 4; i++) begin
      check_val({tag, "_rec_cand"}, {30'd0, rc[i]}, i);
      check_val({tag, "_rec_count"}, {28'd0, rn[i]}, {28'd0, stub[i]});
    end
    check_val({tag, "_ndone"}, ndone, 1);
    check_val({tag, "_done_cyc"}, done_cyc, 60 + stall_len);
    check_val({tag, "_winner"}, {30'd0, winner}, {30'd0, exp_win});
    check_val({tag, "_tie"}, {31'd0, tie}, {31'd0, exp_tie});
    check_val({tag, "_busy_end"}, {31'd0, busy}, 0);
    if (stall_len > 0) begin
      check_val({tag, "_stall_len"}, stalled, stall_len);
      check_val({tag, "_stall_hold"}, bad_stall, 0);
    end
  endtask

  initial begin
    int bad;
    reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    set_stub(4'd0, 4'd0, 4'd0, 4'd0);
    #3;
    check_val("rst_buttons", {28'd0, b4, b3, b2, b1}, 0);
    check_val("rst_mode", {31'd0, mode}, 0);
    check_val("rst_valid", {31'd0, out_valid}, 0);
    check_val("rst_cand", {30'd0, out_cand}, 0);
    check_val("rst_count", {28'd0, out_count}, 0);
    check_val("rst_busy_done", {30'd0, busy, done}, 0);
    check_val("rst_winner_tie", {29'd0, winner, tie}, 0);
    @(negedge clock);
    reset = 1'b1;

    set_stub(4'd2, 4'd1, 4'd0, 4'd0);
    run_readout("basic", 0, 1'b0, 2'd0, 1'b0);

    set_stub(4'd3, 4'd3, 4'd1, 4'd3);
    run_readout("tie3", 0, 1'b0, 2'd0, 1'b1);

    set_stub(4'd5, 4'd9, 4'd9, 4'd4);
    run_readout("stall", 5, 1'b0, 2'd1, 1'b1);

    set_stub(4'd7, 4'd2, 4'd11, 4'd11);
    run_readout("repulse", 0, 1'b1, 2'd2, 1'b1);

    // Abort in the middle of candidate 3's press (cycles 28..39).
    set_stub(4'd1, 4'd2, 4'd3, 4'd4);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      start = 1'b0;
    end
    check_val("abort_pre_b3", {28'd0, b4, b3, b2, b1}, 4'b0100);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    start = 1'b0;
    check_val("abort_buttons", {28'd0, b4, b3, b2, b1}, 0);
    check_val("abort_mode", {31'd0, mode}, 0);
    check_val("abort_busy", {31'd0, busy}, 0);
    bad = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clock);
      if (out_valid || done || busy) bad++;
    end
    check_val("abort_quiet", bad, 0);

    // Reset asserted between edges during the gap after candidate 1.
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    for (int c = 0; c < 13; c++) begin
      @(negedge clock);
      start = 1'b0;
    end
    check_val("gap_mode", {27'd0, mode, b4, b3, b2, b1}, 5'b10000);
    #2;
    reset = 1'b0;
    #1;
    check_val("arst_outputs", {23'd0, mode, b4, b3, b2, b1, out_valid, busy, done, tie}, 0);
    check_val("arst_winner", {30'd0, winner}, 0);
    @(negedge clock);
    reset = 1'b1;
    set_stub(4'd0, 4'd0, 4'd0, 4'd15);
    run_readout("after_rst", 0, 1'b0, 2'd3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
